// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor controller.
package serial_add_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requester (master) and the serial adder (slave).
interface serial_add_ctrl_if
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic             sub;
  logic             ci;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             ovf;

  modport master (
    output start, sub, ci, a, b,
    input  busy, done, sum, co, ovf
  );

  modport slave (
    input  start, sub, ci, a, b,
    output busy, done, sum, co, ovf
  );

endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// Single 1-bit full adder shared by every bit position of the serial datapath.
module fa_cell (
  output logic s,
  output logic co,
  input  logic a,
  input  logic b,
  input  logic ci
);

  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell stepped over WIDTH cycles.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter  int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_ctrl_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic cell_s;
  logic cell_co;
  logic last_bit;

  fa_cell u_fa (
    .s  (cell_s),
    .co (cell_co),
    .a  (opa_q[0]),
    .b  (opb_q[0]),
    .ci (carry_q)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_bit)  state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = (state_q == FIN);
    bus.sum  = sum_q;
    bus.co   = co_q;
    bus.ovf  = ovf_q;
  end

  // The result registers load on the edge into FIN so they are already valid
  // while done is high; carry_q at that point is the carry into the MSB.
  always_comb begin
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          opa_d   = bus.a;
          opb_d   = (bus.sub == MODE_SUB) ? ~bus.b : bus.b;
          carry_d = (bus.sub == MODE_ADD) ? bus.ci : 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        acc_d   = {cell_s, acc_q[WIDTH-1:1]};
        carry_d = cell_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          sum_d = {cell_s, acc_q[WIDTH-1:1]};
          co_d  = cell_co;
          ovf_d = carry_q ^ cell_co;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: arithmetic reference model, done-triggered monitor.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on the operand values.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sub);
    exp_t   e;
    longint ua, ub, sa, sb, u, s, lim;
    lim = longint'(1) << W;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = a[W-1] ? ua - lim : ua;
    sb  = b[W-1] ? ub - lim : ub;
    if (sub) begin
      u    = ua - ub;
      s    = sa - sb;
      e.co = (ua >= ub);
    end else begin
      u    = ua + ub + longint'(ci);
      s    = sa + sb + longint'(ci);
      e.co = (u >= lim);
    end
    e.sum = u[W-1:0];
    e.ovf = (s > (lim / 2) - 1) || (s < -(lim / 2));
    return e;
  endfunction

  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("sum", bus.sum, mon_e.sum);
        check("co",  bus.co,  mon_e.co);
        check("ovf", bus.ovf, mon_e.ovf);
      end
    end
  end

  task automatic rand_inputs();
    bus.a   = W'($urandom);
    bus.b   = W'($urandom);
    bus.ci  = 1'($urandom_range(0, 1));
    bus.sub = 1'($urandom_range(0, 1));
  endtask

  // One operation from IDLE; pulse_at>0 raises start for one edge at that cycle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic sub, input int pulse_at);
    exp_t e;
    int   lat;
    int   nbusy;
    e = model(a, b, ci, sub);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.ci = ci; bus.sub = sub; bus.start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    lat   = 0;
    nbusy = 0;
    for (int k = 1; k <= 3 * W + 10 && lat == 0; k++) begin
      @(negedge clk);
      bus.start = (k == pulse_at);
      rand_inputs();
      if (bus.busy) nbusy++;
      if (bus.done) lat = k;
    end
    check("latency", lat, W + 1);
    check("busy_cycles", nbusy, W);
    @(negedge clk);
    bus.start = 1'b0;
    check("idle_after_done", {bus.busy, bus.done}, 0);
    check("sum_hold", bus.sum, e.sum);
  endtask

  initial begin
    int   nd0;
    int   got;
    int   t_prev;
    logic [W-1:0] ra, rb;
    logic rci, rsub;

    rst = 1'b1;
    bus.start = 1'b0; bus.sub = 1'b0; bus.ci = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_sum",  bus.sum,  0);
    check("reset_co",   bus.co,   0);
    check("reset_ovf",  bus.ovf,  0);
    rst = 1'b0;

    do_op(8'h35, 8'h4A, 1'b0, 1'b0, 0);
    do_op(8'hFF, 8'h01, 1'b1, 1'b0, 0);
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, 0);
    do_op(8'h10, 8'h20, 1'b0, 1'b1, 0);
    do_op(8'h80, 8'h01, 1'b1, 1'b1, 0);

    // start during RUN and during FIN must not be queued
    nd0 = n_done;
    do_op(8'h35, 8'h4A, 1'b0, 1'b0, 3);
    do_op(8'hC3, 8'h5A, 1'b1, 1'b0, W + 1);
    repeat (2 * W) @(negedge clk);
    check("protected_done_count", n_done - nd0, 2);

    // Reset in the fourth RUN cycle aborts the operation
    nd0 = n_done;
    @(negedge clk);
    bus.a = 8'h12; bus.b = 8'h34; bus.ci = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_before_abort", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_sum",  bus.sum,  0);
    check("abort_co",   bus.co,   0);
    check("abort_ovf",  bus.ovf,  0);
    rst = 1'b0;
    repeat (3 * W) @(negedge clk);
    check("abort_no_done", n_done - nd0, 0);

    // rst and start in the same cycle: reset wins
    bus.start = 1'b1; rst = 1'b1;
    @(negedge clk);
    check("rst_beats_start", bus.busy, 0);
    bus.start = 1'b0; rst = 1'b0;
    do_op(8'h5A, 8'hA5, 1'b1, 1'b0, 0);

    // start held high: back-to-back operations every W+2 cycles
    @(negedge clk);
    ra = W'($urandom); rb = W'($urandom);
    rci = 1'($urandom_range(0, 1)); rsub = 1'($urandom_range(0, 1));
    bus.a = ra; bus.b = rb; bus.ci = rci; bus.sub = rsub; bus.start = 1'b1;
    exp_q.push_back(model(ra, rb, rci, rsub));
    t_prev = 0;
    for (int op = 0; op < 3; op++) begin
      got = 0;
      for (int k = 0; k < 3 * W + 10 && got == 0; k++) begin
        @(negedge clk);
        if (bus.done) got = 1;
      end
      check("b2b_done_seen", got, 1);
      if (op > 0) check("b2b_spacing", cyc - t_prev, W + 2);
      t_prev = cyc;
      if (op < 2) begin
        ra = W'($urandom); rb = W'($urandom);
        rci = 1'($urandom_range(0, 1)); rsub = 1'($urandom_range(0, 1));
        bus.a = ra; bus.b = rb; bus.ci = rci; bus.sub = rsub;
        exp_q.push_back(model(ra, rb, rci, rsub));
      end else begin
        bus.start = 1'b0;
      end
    end
    @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      rci = 1'($urandom_range(0, 1)); rsub = 1'($urandom_range(0, 1));
      do_op(ra, rb, rci, rsub, 0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
